fwrisc_regfile_wctrl: RTL and testbench
=======================================

# fwrisc_regfile_wctrl

Write-port controller for the FWRISC register file. It owns the single `rd_waddr`/`rd_wdata`/`rd_wen` write port and shares it between the core writeback path, the trap CSR update sequence and a debug write port. After reset it first clears GPRs r1..r31, because the register file array itself has no synthesizable reset. It sits directly in front of the register file's write inputs.

## Interface
Parameters:
- `ENABLE_CLEAR`, 1 — run the post-reset GPR clear sequence; 0 = skip it and start in IDLE.
- `MEPC_ADDR`, 6'h29 — regfile address of mepc.
- `MCAUSE_ADDR`, 6'h2A — regfile address of mcause.
- `MTVAL_ADDR`, 6'h2B — regfile address of mtval.
- `DBG_MAX_WAIT`, 4 — number of IDLE cycles a pending debug request waits before it outranks writeback (range 1..7).

Ports:
- `clock` in 1 — the block's single clock.
- `reset` in 1 — asynchronous, active-low reset.
- `wb_req` in 1 — core writeback request.
- `wb_addr` in 6 — writeback target address.
- `wb_data` in 32 — writeback data.
- `wb_ack` out 1 — writeback accepted this cycle (combinational).
- `trap_req` in 1 — trap CSR update request; held until `trap_ack`.
- `trap_epc` in 32 — value for mepc.
- `trap_cause` in 32 — value for mcause.
- `trap_tval` in 32 — value for mtval.
- `trap_ack` out 1 — trap sequence finishing (combinational).
- `dbg_req` in 1 — debug write request.
- `dbg_addr` in 6 — debug target address.
- `dbg_data` in 32 — debug data.
- `dbg_ack` out 1 — debug write accepted this cycle (combinational).
- `rd_waddr` out 6 — regfile write address (registered).
- `rd_wdata` out 32 — regfile write data (registered).
- `rd_wen` out 1 — regfile write enable (registered).
- `wr_drop` out 1 — one-cycle pulse (registered): an accepted write was discarded.
- `init_done` out 1 — clear sequence complete (registered).

## Operation
- States: INIT, IDLE, T_CAUSE, T_TVAL.
- Reset state:
  - INIT when `ENABLE_CLEAR`=1, otherwise IDLE.
  - Reset output values: `rd_wen`=0, `rd_waddr`=0, `rd_wdata`=0, `wr_drop`=0, `init_done`=!ENABLE_CLEAR.
  - Internal: clear counter=1, dbg_age=0.
- INIT:
  - Each cycle, registers a write of 0 to address = clear counter, then increments the counter.
  - In the cycle the counter is 31, moves to IDLE and sets `init_done` (stays set until reset).
  - All acks are 0 while in INIT.
- IDLE arbitration, in priority order:
  1. `trap_req`.
  2. `dbg_req` when dbg_age==DBG_MAX_WAIT.
  3. `wb_req`.
  4. `dbg_req`.
- IDLE grant to trap:
  - Captures `trap_cause` and `trap_tval` into internal registers.
  - Registers the write mepc <= `trap_epc` and moves to T_CAUSE.
- T_CAUSE: registers the mcause write, moves to T_TVAL.
- T_TVAL: registers the mtval write, asserts `trap_ack`, moves to IDLE.
- Trap sequence is atomic: `wb_ack`=`dbg_ack`=0 in T_CAUSE and T_TVAL.
- Grant to wb or dbg:
  - Asserts that port's ack and registers its address and data.
  - The address is dropped if it is 0 or if addr[5:3]==3'b100 (read-only CSR window). In that case `rd_wen`=0 and `wr_drop`=1 on the next cycle; the ack is still given.
- dbg_age:
  - Increments, saturating at DBG_MAX_WAIT, on each IDLE cycle where `dbg_req`=1 and debug is not granted.
  - Clears to 0 on a debug grant or when `dbg_req`=0.
  - Holds its value outside IDLE.
- A cycle with no grant registers `rd_wen`=0 and `wr_drop`=0.
- Requesters hold req/addr/data stable until their ack is sampled high, and may change them on the following cycle.

## Timing
- Grant cycle N (ack high) -> `rd_*` carry the write in cycle N+1, and the regfile captures it at the end of N+1.
- Trap accepted in cycle N:
  - mepc write in N+1, mcause in N+2, mtval in N+3.
  - `trap_ack` high in N+2.
  - `trap_req` must be low, or start a new trap, by N+3. A new trap can be accepted at the earliest in N+3.
- INIT with `ENABLE_CLEAR`=1: the first edge after reset release is N; writes to r1..r31 appear in N+1..N+31 and `init_done`=1 from N+31.
- Back-to-back wb grants write on consecutive cycles, sustaining 1 write/cycle.
- Asynchronous assertion of `reset` at any point, including mid-trap or mid-INIT:
  - Immediately forces all reset values.
  - Any in-flight trap sequence is abandoned with no `trap_ack`.
  - INIT restarts from r1.

## Test plan
- Reset release with `ENABLE_CLEAR`=1, no requests -> 31 writes (addr 1..31, data 0) on consecutive cycles, then `init_done`=1 and `rd_wen`=0.
- IDLE, `wb_req` with addr 5, data 0xDEADBEEF -> `wb_ack` in the same cycle; next cycle `rd_wen`=1, `rd_waddr`=5, `rd_wdata`=0xDEADBEEF.
- `trap_req` and `wb_req` asserted together with epc=0x100, cause=0xB, tval=0x0 -> writes 0x29<=0x100, 0x2A<=0xB, 0x2B<=0 on three consecutive cycles; `trap_ack` in the second cycle after acceptance; `wb_ack` only after the sequence returns to IDLE.
- `wb_req` held continuously while `dbg_req` is asserted -> `dbg_ack` granted on the 5th IDLE cycle (dbg_age reaches 4); `wb_ack` resumes the next cycle.
- `wb_req` with addr 0, then `wb_req` with addr 0x21 -> both acked, `rd_wen`=0 and `wr_drop`=1 on each following cycle.
- `reset` asserted in the T_CAUSE cycle -> outputs go to reset values immediately, no `trap_ack`, INIT restarts at r1 after release.

Source files
------------

// File: rtl/fwrisc_regfile_wctrl.sv
// rtl/fwrisc_regfile_wctrl.sv - register file write-port arbiter with post-reset GPR clear
`timescale 1ns/1ps
module fwrisc_regfile_wctrl #(
   parameter bit          ENABLE_CLEAR = 1'b1,
   parameter logic [5:0]  MEPC_ADDR    = 6'h29,
   parameter logic [5:0]  MCAUSE_ADDR  = 6'h2A,
   parameter logic [5:0]  MTVAL_ADDR   = 6'h2B,
   parameter int unsigned DBG_MAX_WAIT = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wb_req,
   input  logic [5:0]  wb_addr,
   input  logic [31:0] wb_data,
   output logic        wb_ack,
   input  logic        trap_req,
   input  logic [31:0] trap_epc,
   input  logic [31:0] trap_cause,
   input  logic [31:0] trap_tval,
   output logic        trap_ack,
   input  logic        dbg_req,
   input  logic [5:0]  dbg_addr,
   input  logic [31:0] dbg_data,
   output logic        dbg_ack,
   output logic [5:0]  rd_waddr,
   output logic [31:0] rd_wdata,
   output logic        rd_wen,
   output logic        wr_drop,
   output logic        init_done
);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_T_CAUSE,
      S_T_TVAL
   } state_t;

   localparam state_t     RESET_STATE = ENABLE_CLEAR ? S_INIT : S_IDLE;
   localparam logic [2:0] DBG_AGE_MAX = 3'(DBG_MAX_WAIT);

   state_t      state, state_nxt;
   logic [4:0]  clr_cnt, clr_cnt_nxt;
   logic [2:0]  dbg_age, dbg_age_nxt;
   logic [31:0] cause_q, cause_nxt;
   logic [31:0] tval_q, tval_nxt;
   logic [5:0]  waddr_nxt;
   logic [31:0] wdata_nxt;
   logic        wen_nxt;
   logic        drop_nxt;
   logic        init_done_nxt;
   logic        dbg_urgent;
   logic        dbg_grant;

   // r0 is hard-wired and 0x20..0x27 is the read-only CSR window
   function automatic logic is_dropped(input logic [5:0] a);
      return (a == 6'd0) || (a[5:3] == 3'b100);
   endfunction

   assign dbg_urgent = dbg_req && (dbg_age == DBG_AGE_MAX);

   // Next-state, arbitration and the write to register for the following cycle
   always_comb begin
      state_nxt     = state;
      clr_cnt_nxt   = clr_cnt;
      dbg_age_nxt   = dbg_age;
      cause_nxt     = cause_q;
      tval_nxt      = tval_q;
      waddr_nxt     = rd_waddr;
      wdata_nxt     = rd_wdata;
      wen_nxt       = 1'b0;
      drop_nxt      = 1'b0;
      init_done_nxt = init_done;
      wb_ack        = 1'b0;
      dbg_ack       = 1'b0;
      trap_ack      = 1'b0;
      dbg_grant     = 1'b0;

      case (state)
         S_INIT: begin
            waddr_nxt   = {1'b0, clr_cnt};
            wdata_nxt   = 32'd0;
            wen_nxt     = 1'b1;
            clr_cnt_nxt = clr_cnt + 5'd1;
            if (clr_cnt == 5'd31) begin
               state_nxt     = S_IDLE;
               init_done_nxt = 1'b1;
            end
         end

         S_IDLE: begin
            if (trap_req) begin
               waddr_nxt = MEPC_ADDR;
               wdata_nxt = trap_epc;
               wen_nxt   = 1'b1;
               cause_nxt = trap_cause;
               tval_nxt  = trap_tval;
               state_nxt = S_T_CAUSE;
            end else if (dbg_urgent || (dbg_req && !wb_req)) begin
               dbg_grant = 1'b1;
               dbg_ack   = 1'b1;
               waddr_nxt = dbg_addr;
               wdata_nxt = dbg_data;
               wen_nxt   = !is_dropped(dbg_addr);
               drop_nxt  = is_dropped(dbg_addr);
            end else if (wb_req) begin
               wb_ack    = 1'b1;
               waddr_nxt = wb_addr;
               wdata_nxt = wb_data;
               wen_nxt   = !is_dropped(wb_addr);
               drop_nxt  = is_dropped(wb_addr);
            end

            // Starvation guard: a waiting debug request ages until it outranks writeback
            if (!dbg_req || dbg_grant) begin
               dbg_age_nxt = 3'd0;
            end else if (dbg_age != DBG_AGE_MAX) begin
               dbg_age_nxt = dbg_age + 3'd1;
            end
         end

         S_T_CAUSE: begin
            waddr_nxt = MCAUSE_ADDR;
            wdata_nxt = cause_q;
            wen_nxt   = 1'b1;
            state_nxt = S_T_TVAL;
         end

         S_T_TVAL: begin
            waddr_nxt = MTVAL_ADDR;
            wdata_nxt = tval_q;
            wen_nxt   = 1'b1;
            trap_ack  = 1'b1;
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt = RESET_STATE;
         end
      endcase
   end

   // State and registered write-port outputs; reset abandons any trap and restarts the clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= RESET_STATE;
         clr_cnt   <= 5'd1;
         dbg_age   <= 3'd0;
         cause_q   <= 32'd0;
         tval_q    <= 32'd0;
         rd_waddr  <= 6'd0;
         rd_wdata  <= 32'd0;
         rd_wen    <= 1'b0;
         wr_drop   <= 1'b0;
         init_done <= !ENABLE_CLEAR;
      end else begin
         state     <= state_nxt;
         clr_cnt   <= clr_cnt_nxt;
         dbg_age   <= dbg_age_nxt;
         cause_q   <= cause_nxt;
         tval_q    <= tval_nxt;
         rd_waddr  <= waddr_nxt;
         rd_wdata  <= wdata_nxt;
         rd_wen    <= wen_nxt;
         wr_drop   <= drop_nxt;
         init_done <= init_done_nxt;
      end
   end

endmodule

// File: tb/tb_fwrisc_regfile_wctrl.sv
// tb/tb_fwrisc_regfile_wctrl.sv - scoreboard bench for fwrisc_regfile_wctrl
`timescale 1ns/1ps
module tb_fwrisc_regfile_wctrl;

   logic        clock;
   logic        reset;
   logic        wb_req;
   logic [5:0]  wb_addr;
   logic [31:0] wb_data;
   logic        wb_ack;
   logic        trap_req;
   logic [31:0] trap_epc;
   logic [31:0] trap_cause;
   logic [31:0] trap_tval;
   logic        trap_ack;
   logic        dbg_req;
   logic [5:0]  dbg_addr;
   logic [31:0] dbg_data;
   logic        dbg_ack;
   logic [5:0]  rd_waddr;
   logic [31:0] rd_wdata;
   logic        rd_wen;
   logic        wr_drop;
   logic        init_done;

   typedef struct packed {
      logic        wen;
      logic [5:0]  addr;
      logic [31:0] data;
      logic        drop;
      logic        init;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   logic mon_en;
   int   n_checks;
   int   n_errors;
   int   cyc_no;

   fwrisc_regfile_wctrl dut (
      .clock      (clock),
      .reset      (reset),
      .wb_req     (wb_req),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .wb_ack     (wb_ack),
      .trap_req   (trap_req),
      .trap_epc   (trap_epc),
      .trap_cause (trap_cause),
      .trap_tval  (trap_tval),
      .trap_ack   (trap_ack),
      .dbg_req    (dbg_req),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .dbg_ack    (dbg_ack),
      .rd_waddr   (rd_waddr),
      .rd_wdata   (rd_wdata),
      .rd_wen     (rd_wen),
      .wr_drop    (wr_drop),
      .init_done  (init_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic push_exp(input logic wen, input logic [5:0] addr, input logic [31:0] data,
                           input logic drop, input logic init);
      exp_t e;
      e.wen  = wen;
      e.addr = addr;
      e.data = data;
      e.drop = drop;
      e.init = init;
      sb.push_back(e);
   endtask

   // One clock cycle: drive requests, check the combinational acks, queue the write expected next cycle
   task automatic cyc(input logic t_req, input logic w_req, input logic [5:0] w_addr,
                      input logic [31:0] w_data, input logic d_req, input logic [5:0] d_addr,
                      input logic [31:0] d_data, input logic [2:0] e_ack,
                      input logic e_wen, input logic [5:0] e_addr, input logic [31:0] e_data,
                      input logic e_drop, input logic e_init);
      @(posedge clock);
      #1;
      trap_req = t_req;
      wb_req   = w_req;
      wb_addr  = w_addr;
      wb_data  = w_data;
      dbg_req  = d_req;
      dbg_addr = d_addr;
      dbg_data = d_data;
      @(negedge clock);
      cyc_no++;
      check($sformatf("acks{trap,dbg,wb}@%0d", cyc_no), {29'd0, trap_ack, dbg_ack, wb_ack}, {29'd0, e_ack});
      push_exp(e_wen, e_addr, e_data, e_drop, e_init);
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 3'b000, 0, 6'd0, 32'd0, 0, 1);
   endtask

   // Release reset and expect r1..r31 cleared on consecutive cycles; wb_req during INIT must not be acked
   task automatic run_init();
      @(negedge clock);
      reset = 1'b1;
      push_exp(1, 6'd1, 32'd0, 0, 0);
      mon_en = 1'b1;
      for (int i = 2; i <= 31; i++) begin
         cyc(0, (i < 8), 6'd9, 32'h99, 0, 6'd0, 32'd0, 3'b000, 1, 6'(i), 32'd0, 0, (i == 31));
      end
      idle_cyc();
   endtask

   // Output monitor: compare the registered write port against the scoreboard head
   initial begin
      forever begin
         @(posedge clock);
         #2;
         if (mon_en) begin
            if (sb.size() == 0) begin
               check("sb_underflow", 32'd1, 32'd0);
            end else begin
               mon_e = sb.pop_front();
               check("rd_wen", {31'd0, rd_wen}, {31'd0, mon_e.wen});
               if (mon_e.wen) begin
                  check("rd_waddr", {26'd0, rd_waddr}, {26'd0, mon_e.addr});
                  check("rd_wdata", rd_wdata, mon_e.data);
               end
               check("wr_drop", {31'd0, wr_drop}, {31'd0, mon_e.drop});
               check("init_done", {31'd0, init_done}, {31'd0, mon_e.init});
            end
         end
      end
   end

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      cyc_no     = 0;
      mon_en     = 1'b0;
      reset      = 1'b0;
      wb_req     = 1'b0;
      wb_addr    = 6'd0;
      wb_data    = 32'd0;
      trap_req   = 1'b0;
      trap_epc   = 32'd0;
      trap_cause = 32'd0;
      trap_tval  = 32'd0;
      dbg_req    = 1'b0;
      dbg_addr   = 6'd0;
      dbg_data   = 32'd0;

      repeat (2) @(negedge clock);
      check("rst_rd_wen", {31'd0, rd_wen}, 32'd0);
      check("rst_rd_waddr", {26'd0, rd_waddr}, 32'd0);
      check("rst_rd_wdata", rd_wdata, 32'd0);
      check("rst_wr_drop", {31'd0, wr_drop}, 32'd0);
      check("rst_init_done", {31'd0, init_done}, 32'd0);

      run_init();

      // Plain writeback
      cyc(0, 1, 6'd5, 32'hDEADBEEF, 0, 6'd0, 32'd0, 3'b001, 1, 6'd5, 32'hDEADBEEF, 0, 1);
      idle_cyc();

      // Trap outranks a simultaneous writeback; wb waits for the sequence to finish
      trap_epc   = 32'h100;
      trap_cause = 32'hB;
      trap_tval  = 32'h0;
      cyc(1, 1, 6'd7, 32'h1234, 0, 6'd0, 32'd0, 3'b000, 1, 6'h29, 32'h100, 0, 1);
      cyc(1, 1, 6'd7, 32'h1234, 0, 6'd0, 32'd0, 3'b000, 1, 6'h2A, 32'hB, 0, 1);
      cyc(1, 1, 6'd7, 32'h1234, 0, 6'd0, 32'd0, 3'b100, 1, 6'h2B, 32'h0, 0, 1);
      cyc(0, 1, 6'd7, 32'h1234, 0, 6'd0, 32'd0, 3'b001, 1, 6'd7, 32'h1234, 0, 1);
      idle_cyc();

      // Debug starved by continuous writeback wins on the 5th IDLE cycle
      for (int i = 0; i < 4; i++) begin
         cyc(0, 1, 6'(10 + i), 32'(i + 1), 1, 6'd3, 32'hD0D0, 3'b001, 1, 6'(10 + i), 32'(i + 1), 0, 1);
      end
      cyc(0, 1, 6'd14, 32'd5, 1, 6'd3, 32'hD0D0, 3'b010, 1, 6'd3, 32'hD0D0, 0, 1);
      cyc(0, 1, 6'd14, 32'd5, 0, 6'd0, 32'd0, 3'b001, 1, 6'd14, 32'd5, 0, 1);
      idle_cyc();

      // Dropped addresses: r0 and the 0x20..0x27 window; 0x28 is just outside it
      cyc(0, 1, 6'h00, 32'h11, 0, 6'd0, 32'd0, 3'b001, 0, 6'd0, 32'd0, 1, 1);
      cyc(0, 1, 6'h21, 32'h22, 0, 6'd0, 32'd0, 3'b001, 0, 6'd0, 32'd0, 1, 1);
      cyc(0, 1, 6'h20, 32'h33, 0, 6'd0, 32'd0, 3'b001, 0, 6'd0, 32'd0, 1, 1);
      cyc(0, 1, 6'h28, 32'h28, 0, 6'd0, 32'd0, 3'b001, 1, 6'h28, 32'h28, 0, 1);
      cyc(0, 0, 6'd0, 32'd0, 1, 6'h00, 32'hAA, 3'b010, 0, 6'd0, 32'd0, 1, 1);
      cyc(0, 0, 6'd0, 32'd0, 1, 6'h1F, 32'h5555, 3'b010, 1, 6'h1F, 32'h5555, 0, 1);
      idle_cyc();

      // Reset asserted while the trap sequence sits in T_CAUSE
      trap_epc   = 32'h200;
      trap_cause = 32'h5;
      trap_tval  = 32'hABC;
      cyc(1, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 3'b000, 1, 6'h29, 32'h200, 0, 1);
      @(posedge clock);
      #3;
      mon_en = 1'b0;
      reset  = 1'b0;
      #1;
      check("midtrap_rd_wen", {31'd0, rd_wen}, 32'd0);
      check("midtrap_rd_waddr", {26'd0, rd_waddr}, 32'd0);
      check("midtrap_rd_wdata", rd_wdata, 32'd0);
      check("midtrap_wr_drop", {31'd0, wr_drop}, 32'd0);
      check("midtrap_init_done", {31'd0, init_done}, 32'd0);
      check("midtrap_trap_ack", {31'd0, trap_ack}, 32'd0);
      check("midtrap_sb_left", 32'(sb.size()), 32'd0);
      sb.delete();
      trap_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check("rst_hold_trap_ack", {31'd0, trap_ack}, 32'd0);
         check("rst_hold_rd_wen", {31'd0, rd_wen}, 32'd0);
      end

      run_init();
      idle_cyc();

      @(posedge clock);
      #3;
      check("sb_drain", 32'(sb.size()), 32'd0);
      mon_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
